gpio_byte_stream_rx: RTL and testbench

On-chip receiver for the GPIO-pad input byte stream of the HyperSpace user project. It accepts 8-bit bytes from the mprj_io pads under a valid/ready/last handshake and undoes the pad bit-order swap. It packs the bytes into 32-bit sample words and presents them on an internal AXI4-Stream master port feeding the spectrometer datapath. It is the core-side counterpart of the byte transmitter that drives mprj_io[37:28].

---
 rtl/hyperspace_stream_pkg.sv | 19 +
 rtl/stream_fifo2.sv | 46 ++++
 rtl/gpio_byte_stream_rx.sv | 115 +++++++++++
 tb/tb_gpio_byte_stream_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperspace_stream_pkg.sv
// Shared widths and FIFO entry type for the HyperSpace pad byte stream (RX and TX sides).
package hyperspace_stream_pkg;
  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 32;
  localparam int CNT_W    = 16;
  localparam int KEEP_W   = SAMPLE_W / BYTE_W;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic [KEEP_W-1:0]   keep;
    logic                last;
  } stream_entry_t;

  function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    for (int i = 0; i < BYTE_W; i++) r[i] = b[BYTE_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO; head entry drives the output directly, count is registered.
module stream_fifo2
  import hyperspace_stream_pkg::*;
(
  input  logic          clock,
  input  logic          RSTB,
  input  logic          push,
  input  stream_entry_t in_entry,
  input  logic          pop,
  output stream_entry_t out_entry,
  output logic [1:0]    count
);
  stream_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0]    count_q, count_d, remain;
  logic          do_pop, do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    remain  = count_q - {1'b0, do_pop};
    if (do_pop) head_d = tail_q;
    // New entry lands behind whatever survives the pop, preserving order.
    if (do_push) begin
      if (remain == 2'd0) head_d = in_entry;
      else                tail_d = in_entry;
    end
    count_d = remain + {1'b0, do_push};
  end

  always_ff @(posedge clock) begin
    if (RSTB) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_entry = head_q;
  assign count     = count_q;
endmodule

// File: rtl/gpio_byte_stream_rx.sv
// Pad byte-stream receiver: undoes pad bit order, packs bytes MSB-first into words,
// and streams them out through a 2-entry FIFO with frame/word statistics.
module gpio_byte_stream_rx
  import hyperspace_stream_pkg::*;
#(
  parameter int BYTES_PER_WORD = KEEP_W,
  parameter bit REVERSE_BITS   = 1'b1
) (
  input  logic                clock,
  input  logic                RSTB,
  input  logic [BYTE_W-1:0]   pad_in_data,
  input  logic                pad_in_valid,
  input  logic                pad_in_last,
  output logic                pad_in_ready,
  output logic [SAMPLE_W-1:0] m_data,
  output logic [KEEP_W-1:0]   m_keep,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic [CNT_W-1:0]    frame_len,
  output logic [CNT_W-1:0]    word_cnt,
  output logic                frame_err
);
  localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic                running_q, running_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [SAMPLE_W-1:0] word_q, word_d, word_fill;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d, frame_len_q, frame_len_d, word_cnt_q, word_cnt_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          fifo_count;
  logic                accept, push, pop, last_lane;
  logic [BYTE_W-1:0]   byte_x;
  stream_entry_t       push_entry, head;

  assign pad_in_ready = running_q && (fifo_count < 2'd2);
  assign byte_x       = REVERSE_BITS ? bit_rev8(pad_in_data) : pad_in_data;
  assign m_valid      = (fifo_count != 2'd0);
  assign pop          = m_valid && m_ready;

  always_comb begin
    running_d   = 1'b1;
    lane_d      = lane_q;
    word_d      = word_q;
    fcnt_d      = fcnt_q;
    frame_len_d = frame_len_q;
    frame_err_d = frame_err_q;
    word_cnt_d  = word_cnt_q;
    accept      = pad_in_valid && pad_in_ready;
    last_lane   = (lane_q == LANE_W'(BYTES_PER_WORD-1));
    push        = accept && (last_lane || pad_in_last);
    // word_q keeps unfilled lanes at zero, so a partial push needs no masking.
    word_fill   = word_q;
    push_entry  = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (lane_q == LANE_W'(k)) word_fill[SAMPLE_W-1-BYTE_W*k -: BYTE_W] = byte_x;
      push_entry.keep[KEEP_W-1-k] = (LANE_W'(k) <= lane_q);
    end
    push_entry.data = word_fill;
    push_entry.last = pad_in_last;

    if (accept) begin
      fcnt_d = fcnt_q + 16'd1;
      word_d = word_fill;
      lane_d = lane_q + {{(LANE_W-1){1'b0}}, 1'b1};
      if (push) begin
        word_d = '0;
        lane_d = '0;
      end
      if (pad_in_last) begin
        frame_len_d = fcnt_q + 16'd1;
        fcnt_d      = '0;
        if (!last_lane) frame_err_d = 1'b1;
      end
    end
    if (pop) word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (RSTB) begin
      running_q   <= 1'b0;
      lane_q      <= '0;
      word_q      <= '0;
      fcnt_q      <= '0;
      frame_len_q <= '0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      running_q   <= running_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      fcnt_q      <= fcnt_d;
      frame_len_q <= frame_len_d;
      frame_err_q <= frame_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  stream_fifo2 u_fifo (
    .clock     (clock),
    .RSTB      (RSTB),
    .push      (push),
    .in_entry  (push_entry),
    .pop       (pop),
    .out_entry (head),
    .count     (fifo_count)
  );

  assign m_data    = head.data;
  assign m_keep    = head.keep;
  assign m_last    = head.last;
  assign frame_len = frame_len_q;
  assign word_cnt  = word_cnt_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_gpio_byte_stream_rx.sv
// Scoreboard bench for gpio_byte_stream_rx: a byte-queue model predicts words at accept time,
// a negedge monitor pops and compares whenever a word is taken downstream.
module tb_gpio_byte_stream_rx;
  logic        clock = 1'b0;
  logic        RSTB = 1'b1;
  logic [7:0]  pad_in_data = 8'h00;
  logic        pad_in_valid = 1'b0;
  logic        pad_in_last = 1'b0;
  logic        pad_in_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [15:0] frame_len, word_cnt;
  logic        frame_err;

  gpio_byte_stream_rx #(.BYTES_PER_WORD(4), .REVERSE_BITS(1'b1)) dut (
    .clock(clock), .RSTB(RSTB), .pad_in_data(pad_in_data), .pad_in_valid(pad_in_valid),
    .pad_in_last(pad_in_last), .pad_in_ready(pad_in_ready), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .frame_len(frame_len),
    .word_cnt(word_cnt), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } word_t;
  word_t      exp_q[$];
  word_t      log_q[$];
  logic [7:0] buf_q[$];
  int n_cmp = 0, n_err = 0;
  int fcount = 0, m_flen = 0, m_words = 0;
  logic m_ferr = 1'b0;
  int cyc = 0;
  int mode = 1;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (mode == 2) m_ready = 1'($urandom_range(0, 1));
    else           m_ready = (mode == 1);
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: bytes collect in a queue; four bytes or a last byte make one word.
  task automatic model_accept(input logic [7:0] b, input logic l);
    word_t e;
    if (l && buf_q.size() != 3) m_ferr = 1'b1;
    buf_q.push_back(rev8(b));
    fcount++;
    if (l) begin
      m_flen = fcount % 65536;
      fcount = 0;
    end
    if (buf_q.size() == 4 || l) begin
      e.d = 32'h0; e.k = 4'h0; e.l = l;
      for (int k = 0; k < buf_q.size(); k++) begin
        e.d = e.d | (32'(buf_q[k]) << (24 - 8*k));
        e.k[3-k] = 1'b1;
      end
      exp_q.push_back(e);
      buf_q.delete();
    end
  endtask

  always @(negedge clock) begin
    word_t o, e;
    if (RSTB) begin
      exp_q.delete(); buf_q.delete();
      fcount = 0; m_flen = 0; m_ferr = 1'b0; m_words = 0;
    end else begin
      if (m_valid && m_ready) begin
        o.d = m_data; o.k = m_keep; o.l = m_last;
        log_q.push_back(o);
        m_words = (m_words + 1) % 65536;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %h, expected no word", m_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", o.d, e.d);
          check("word_keep", 32'(o.k), 32'(e.k));
          check("word_last", 32'(o.l), 32'(e.l));
        end
      end
      if (pad_in_valid && pad_in_ready) model_accept(pad_in_data, pad_in_last);
    end
  end

  task automatic do_reset();
    RSTB = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", 32'(pad_in_ready), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", m_data, 0);
    check("rst_keep", 32'(m_keep), 0);
    check("rst_frame_len", 32'(frame_len), 0);
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    RSTB = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    pad_in_data = b; pad_in_last = l; pad_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (pad_in_ready && !RSTB) begin
        @(posedge clock); #1;
        pad_in_valid = 1'b0; pad_in_last = 1'b0;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout: got pad_in_ready=0, expected 1 within 200 cycles");
    @(posedge clock); #1;
    pad_in_valid = 1'b0; pad_in_last = 1'b0;
  endtask

  task automatic drain();
    mode = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!m_valid && exp_q.size() == 0) break;
    end
    check("drain_pending", 32'(exp_q.size()), 0);
    check("drain_valid", 32'(m_valid), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    int t0, lb, acc, nl, nk;
    logic [31:0] hold;

    // Long full-word frame at full rate
    mode = 1;
    do_reset();
    lb = log_q.size();
    t0 = cyc;
    for (int i = 0; i < 2048; i++) send_byte(rev8(8'(i)), i == 2047);
    check("throughput_cycles", 32'(cyc - t0), 2048);
    drain();
    check("long_words", 32'(log_q.size() - lb), 512);
    if (log_q.size() >= lb + 512) begin
      check("long_word0", log_q[lb].d, 32'h00010203);
      check("long_word1", log_q[lb+1].d, 32'h04050607);
      check("long_last511", 32'(log_q[lb+511].l), 1);
      nl = 0; nk = 0;
      for (int i = lb; i < lb + 512; i++) begin
        nl += int'(log_q[i].l);
        nk += int'(log_q[i].k != 4'hF);
      end
      check("long_last_count", 32'(nl), 1);
      check("long_partial_keeps", 32'(nk), 0);
    end
    check("long_frame_len", 32'(frame_len), 2048);
    check("long_frame_err", 32'(frame_err), 0);
    check("long_word_cnt", 32'(word_cnt), 512);

    // Pad bit order and one-cycle latency into an empty FIFO
    send_byte(8'h80, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b1);
    check("latency_valid", 32'(m_valid), 1);
    check("bitorder_data", m_data, 32'h01020080);
    drain();

    // Backpressure: the FIFO fills, then the assembler stops taking bytes
    mode = 0;
    repeat (2) begin @(posedge clock); #1; end
    acc = 0;
    pad_in_valid = 1'b1; pad_in_last = 1'b0;
    for (int c = 0; c < 30; c++) begin
      pad_in_data = 8'($urandom);
      @(negedge clock);
      if (pad_in_ready) acc++;
      @(posedge clock); #1;
    end
    pad_in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 8);
    check("bp_ready", 32'(pad_in_ready), 0);
    check("bp_valid", 32'(m_valid), 1);
    check("bp_fifo_words", 32'(exp_q.size()), 2);
    hold = m_data;
    repeat (3) begin @(posedge clock); #1; end
    check("bp_hold_data", m_data, hold);
    drain();
    send_byte(8'h5A, 1'b1);
    drain();

    // Partial last word
    do_reset();
    lb = log_q.size();
    send_byte(rev8(8'hAA), 1'b0);
    send_byte(rev8(8'hBB), 1'b0);
    send_byte(rev8(8'hCC), 1'b0);
    send_byte(rev8(8'hDD), 1'b0);
    send_byte(rev8(8'hEE), 1'b0);
    send_byte(rev8(8'hFF), 1'b1);
    drain();
    check("partial_words", 32'(log_q.size() - lb), 2);
    if (log_q.size() == lb + 2) begin
      check("partial_w0", log_q[lb].d, 32'hAABBCCDD);
      check("partial_k0", 32'(log_q[lb].k), 32'hF);
      check("partial_l0", 32'(log_q[lb].l), 0);
      check("partial_w1", log_q[lb+1].d, 32'hEEFF0000);
      check("partial_k1", 32'(log_q[lb+1].k), 32'hC);
      check("partial_l1", 32'(log_q[lb+1].l), 1);
    end
    check("partial_frame_len", 32'(frame_len), 6);
    check("partial_frame_err", 32'(frame_err), 1);

    // Reset in the middle of a frame, with a byte offered during reset
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    lb = log_q.size();
    RSTB = 1'b1;
    pad_in_valid = 1'b1; pad_in_data = 8'h77;
    @(posedge clock); #1;
    check("midrst_ready_low", 32'(pad_in_ready), 0);
    check("midrst_valid_low", 32'(m_valid), 0);
    RSTB = 1'b0;
    pad_in_valid = 1'b0;
    @(posedge clock); #1;
    check("midrst_ready_high", 32'(pad_in_ready), 1);
    send_byte(rev8(8'h11), 1'b0);
    send_byte(rev8(8'h22), 1'b0);
    send_byte(rev8(8'h33), 1'b0);
    send_byte(rev8(8'h44), 1'b1);
    drain();
    check("midrst_words", 32'(log_q.size() - lb), 1);
    if (log_q.size() == lb + 1) check("midrst_word", log_q[lb].d, 32'h11223344);
    check("midrst_frame_len", 32'(frame_len), 4);

    // Random traffic with random downstream readiness
    do_reset();
    mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      send_byte(8'($urandom), $urandom_range(0, 15) == 0);
    end
    drain();
    check("rand_word_cnt", 32'(word_cnt), 32'(m_words));
    check("rand_frame_len", 32'(frame_len), 32'(m_flen));
    check("rand_frame_err", 32'(frame_err), 32'(m_ferr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
